// File: rtl/fourbit_div_pkg.sv
// Shared definitions for the fourbit_div sequential restoring divider.
//   W_DEFAULT : default operand width in bits.
//   state_t   : divider controller states (IDLE, RUN, DONE).
package fourbit_div_pkg;

    localparam int W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division stage.
//   partial  : shifted partial remainder with the next dividend bit appended
//   divisor  : latched divisor
//   rem_next : partial - divisor when that does not borrow, otherwise partial
//   q_bit    : quotient bit (1 when the subtraction did not borrow)
module div_step
    import fourbit_div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic [W-1:0] partial,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0]   a_ext;
    logic [W:0]   b_inv;
    logic [W:0]   diff;
    logic [W+1:0] carry;

    // partial - divisor as partial + ~divisor + 1, one bit wider than the
    // operands so the sign of the result shows a borrow.
    assign a_ext    = {1'b0, partial};
    assign b_inv    = ~{1'b0, divisor};
    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= W; i++) begin : g_sub
        FullAdder u_fa (
            .a   (a_ext[i]),
            .b   (b_inv[i]),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    // With zero-extended operands the carry-out is set exactly when the sign
    // bit is clear; both say "no borrow".
    assign q_bit    = carry[W+1] & ~diff[W];
    assign rem_next = q_bit ? diff[W-1:0] : partial;

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple subtractor.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module FullAdder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/fourbit_div.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk, rst           : clock, synchronous active-high reset
//   start              : request pulse, accepted in IDLE or DONE
//   dividend, divisor  : unsigned operands captured on an accepted start
//   busy               : high while iterating
//   done               : one-cycle pulse when results are valid
//   quotient/remainder : held results of the last completed division
//   div_by_zero        : last accepted divisor was zero
module fourbit_div
    import fourbit_div_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int               CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(W - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    // Partial remainder never needs its MSB before a shift, so only W-1
    // bits are kept; the final full-width remainder comes from the stage.
    logic [W-2:0]     rem_r;
    logic [W-1:0]     q_r;
    logic [W-1:0]     dvsr_r;
    logic [W-1:0]     step_rem;
    logic             step_q;
    logic [W-1:0]     q_shift;
    logic             accept;

    assign accept  = start && (state != RUN);
    assign q_shift = {q_r[W-2:0], step_q};
    assign busy    = (state == RUN);
    assign done    = (state == DONE);

    div_step #(.W(W)) u_step (
        .partial (({rem_r, q_r[W-1]})),
        .divisor (dvsr_r),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    // Control and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        if (divisor != '0) begin
                            state       <= RUN;
                            count       <= '0;
                            div_by_zero <= 1'b0;
                        end else begin
                            // Divide by zero skips the iteration entirely.
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    count <= count + CNT_W'(1);
                    if (count == LAST) begin
                        quotient  <= q_shift;
                        remainder <= step_rem;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Iteration datapath: shift register {rem, q} and latched divisor.
    always_ff @(posedge clk) begin
        if (accept && (divisor != '0)) begin
            rem_r  <= '0;
            q_r    <= dividend;
            dvsr_r <= divisor;
        end else if (state == RUN) begin
            rem_r <= step_rem[W-2:0];
            q_r   <= q_shift;
        end
    end

endmodule

// File: tb/tb_fourbit_div.sv
module tb_fourbit_div;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dz;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [3:0] quotient, remainder;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    fourbit_div #(.W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        if (b == 4'd0) begin
            e.q = 4'hF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0; e.lat = 5;
        end
        return e;
    endfunction

    // Drives a start request in the current cycle and queues its expected result.
    task automatic drive(input logic [3:0] a, input logic [3:0] b, input bit expect_result);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (expect_result) sb.push_back(model(a, b));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        // start during the second reset cycle must lose to rst
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_ctrl busy=%b done=%b required 0 0", busy, done);
        end
        total++;
        if (quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL reset_data q=%0d r=%0d dz=%b required 0 0 0", quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_basic();
        exp_t e;
        @(negedge clk);
        drive(4'd13, 4'd3, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            total++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                bad++; $display("FAIL basic_busy cyc=%0d busy=%b done=%b required 1 0", i, busy, done);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sb.size() == 0) begin
            bad++; $display("FAIL basic_done done=%b busy=%b required 1 0", done, busy);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                bad++; $display("FAIL basic_result q=%0d r=%0d dz=%b required %0d %0d %b",
                                quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_boundary();
        logic [3:0] ta[4] = '{4'd15, 4'd0, 4'd15, 4'd6};
        logic [3:0] tb[4] = '{4'd15, 4'd5, 4'd1, 4'd7};
        exp_t e;
        int   n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(ta[i], tb[i], 1'b1);
            n = 0;
            do begin
                @(negedge clk); start = 1'b0; n++;
            end while (!done && n < 20);
            total++;
            if (done !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL bnd_done %0d/%0d done=%b required 1", ta[i], tb[i], done);
                sb.delete();
            end else begin
                e = sb.pop_front();
                total++;
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                    bad++; $display("FAIL bnd_result %0d/%0d q=%0d r=%0d dz=%b required %0d %0d %b",
                                    ta[i], tb[i], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                end
                total++;
                if (n !== e.lat) begin
                    bad++; $display("FAIL bnd_latency %0d/%0d got=%0d required %0d", ta[i], tb[i], n, e.lat);
                end
            end
        end
    endtask

    task automatic test_div_zero();
        exp_t e;
        @(negedge clk);
        drive(4'd9, 4'd0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || sb.size() == 0) begin
            bad++; $display("FAIL dz_done done=%b busy=%b required 1 0", done, busy);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                bad++; $display("FAIL dz_result q=%0d r=%0d dz=%b required %0d %0d %b",
                                quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            bad++; $display("FAIL dz_after done=%b busy=%b dz=%b required 0 0 1", done, busy, div_by_zero);
        end
    endtask

    task automatic test_start_busy();
        exp_t e;
        int   n_done = 0;
        @(negedge clk);
        drive(4'd14, 4'd4, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++; $display("FAIL busy_sb empty scoreboard at done");
                    end else begin
                        e = sb.pop_front();
                        if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                            bad++; $display("FAIL busy_result q=%0d r=%0d dz=%b required %0d %0d %b",
                                            quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                        end
                    end
                end
            end
            if (i == 2) drive(4'd3, 4'd1, 1'b0);
        end
        total++;
        if (n_done !== 1) begin
            bad++; $display("FAIL busy_pulses got=%0d required 1", n_done);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   n_done = 0;
        int   n;
        @(negedge clk);
        drive(4'd11, 4'd2, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || quotient !== 4'd0 || remainder !== 4'd0 || div_by_zero !== 1'b0) begin
            bad++; $display("FAIL mid_reset busy=%b done=%b q=%0d r=%0d dz=%b required all 0",
                            busy, done, quotient, remainder, div_by_zero);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        total++;
        if (n_done !== 0) begin
            bad++; $display("FAIL mid_no_done got=%0d required 0", n_done);
        end
        drive(4'd11, 4'd2, 1'b1);
        n = 0;
        do begin
            @(negedge clk); start = 1'b0; n++;
        end while (!done && n < 20);
        total++;
        if (done !== 1'b1 || sb.size() == 0) begin
            bad++; $display("FAIL mid_redo_done done=%b required 1", done);
            sb.delete();
        end else begin
            e = sb.pop_front();
            total++;
            if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                bad++; $display("FAIL mid_redo_result q=%0d r=%0d dz=%b required %0d %0d %b",
                                quotient, remainder, div_by_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          n;
        int          errs_before;
        logic [7:0]  p;
        errs_before = bad;
        @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            p = 8'(i);
            drive(p[7:4], p[3:0], 1'b1);
            n = 0;
            do begin
                @(negedge clk); start = 1'b0; n++;
                total++;
                if (busy && done) begin
                    bad++; $display("FAIL b2b_overlap pair=%0d busy=%b done=%b required not both", i, busy, done);
                end
            end while (!done && n < 20);
            total++;
            if (done !== 1'b1 || sb.size() == 0) begin
                bad++; $display("FAIL b2b_done pair=%0d done=%b required 1", i, done);
                sb.delete();
            end else begin
                e = sb.pop_front();
                total++;
                if (quotient !== e.q || remainder !== e.r || div_by_zero !== e.dz) begin
                    bad++; $display("FAIL b2b_result %0d/%0d q=%0d r=%0d dz=%b required %0d %0d %b",
                                    p[7:4], p[3:0], quotient, remainder, div_by_zero, e.q, e.r, e.dz);
                end
                total++;
                if (n !== e.lat) begin
                    bad++; $display("FAIL b2b_latency %0d/%0d got=%0d required %0d", p[7:4], p[3:0], n, e.lat);
                end
            end
            if (bad - errs_before > 20) break;
        end
        start = 1'b0;
        total++;
        if (sb.size() !== 0) begin
            bad++; $display("FAIL b2b_leftover got=%0d required 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_div_zero();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
